// File: rtl/ex_pkg.sv
// ============================================================================
//  Module      : ex_pkg
//  Description : Shared encodings for the execute stage: ALU select codes,
//                M-extension funct3 values and the mul/div FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ex_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_iter.sv
// ============================================================================
//  Module      : ex_muldiv_iter
//  Description : Iterative multiply (shift-add) / divide (restoring) engine,
//                one bit per cycle on magnitudes, sign fixed up in DONE.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_muldiv_iter
    import ex_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic            hold,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    md_state_t         state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   hi, lo, opb;
    logic [2:0]        op_q;
    logic              neg_q;

    logic              a_sgn, b_sgn, a_neg, b_neg, neg_nxt;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic [XLEN:0]     mul_sum, div_sh;
    logic              div_ge;
    logic [2*XLEN-1:0] prod, prod_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MD_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            MD_IDLE: if (start && !flush) state_nxt = MD_BUSY;
            MD_BUSY: begin
                busy = 1'b1;
                if (flush)                state_nxt = MD_IDLE;
                else if (cnt == LAST_CNT) state_nxt = MD_DONE;
            end
            MD_DONE: begin
                done = 1'b1;
                if (flush || !hold) state_nxt = MD_IDLE;
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        a_sgn   = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
        b_sgn   = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
        a_neg   = a_sgn && a[XLEN-1];
        b_neg   = b_sgn && b[XLEN-1];
        a_abs   = a_neg ? -a : a;
        b_abs   = b_neg ? -b : b;
        // Divide-by-zero keeps an all-ones quotient, so no quotient negation there.
        if (!op[2])     neg_nxt = a_neg ^ b_neg;
        else if (op[1]) neg_nxt = a_neg;
        else            neg_nxt = (a_neg ^ b_neg) && (b != '0);

        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        div_sh  = {hi, lo[XLEN-1]};
        div_ge  = div_sh >= {1'b0, opb};
    end

    // Multiply: hi:lo holds partial product with multiplier in lo.
    // Divide: hi is the running remainder, lo shifts dividend out and quotient in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            opb   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
        end else if (state == MD_IDLE && start && !flush) begin
            cnt   <= '0;
            hi    <= '0;
            op_q  <= op;
            neg_q <= neg_nxt;
            lo    <= op[2] ? a_abs : b_abs;
            opb   <= op[2] ? b_abs : a_abs;
        end else if (state == MD_BUSY) begin
            cnt <= cnt + CNT_W'(1);
            if (op_q[2]) begin
                hi <= div_ge ? (div_sh[XLEN-1:0] - opb) : div_sh[XLEN-1:0];
                lo <= {lo[XLEN-2:0], div_ge};
            end else begin
                hi <= mul_sum[XLEN:1];
                lo <= {mul_sum[0], lo[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        prod   = {hi, lo};
        prod_c = neg_q ? -prod : prod;
        case (op_q)
            MD_MUL:                       result = prod_c[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod_c[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              result = neg_q ? -lo : lo;
            default:                      result = neg_q ? -hi : hi;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ex_stage_md.sv
// ============================================================================
//  Module      : ex_stage_md
//  Description : RISC-V execute stage: forwarding, ALU, branch compare,
//                iterative M-extension unit and the EX/MEM register.
//                Define EX_FAST_MUL_EN for single-cycle MUL* operations.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_stage_md
    import ex_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            flush,
    input  logic            mem_stall,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_DataA,
    input  logic [XLEN-1:0] ex_DataB,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] mem_ALU_out,
    input  logic [XLEN-1:0] wb_WBData,
    input  logic [1:0]      ForwardASel,
    input  logic [1:0]      ForwardBSel,
    input  logic            ASel,
    input  logic            BSel,
    input  logic            BrUn,
    input  logic [3:0]      ALUSel,
    input  logic            MdEn,
    input  logic [2:0]      MdOp,
    output logic            BrEq,
    output logic            BrLT,
    output logic            ex_stall,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_result,
    output logic [XLEN-1:0] mem_DataB
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_out, md_result, next_result;
    logic [SHW-1:0]  shamt;
    logic            md_iter, md_start, md_busy, md_done;

    always_comb begin
        case (ForwardASel)
            2'd1:    fwd_a = wb_WBData;
            2'd2:    fwd_a = mem_ALU_out;
            default: fwd_a = ex_DataA;
        endcase
        case (ForwardBSel)
            2'd1:    fwd_b = wb_WBData;
            2'd2:    fwd_b = mem_ALU_out;
            default: fwd_b = ex_DataB;
        endcase
        op_a  = ASel ? ex_pc : fwd_a;
        op_b  = BSel ? imm : fwd_b;
        shamt = op_b[SHW-1:0];
        BrEq  = (fwd_a == fwd_b);
        BrLT  = BrUn ? (fwd_a < fwd_b) : ($signed(fwd_a) < $signed(fwd_b));
    end

    always_comb begin
        alu_out = '0;
        case (ALUSel)
            ALU_ADD:   alu_out = op_a + op_b;
            ALU_SUB:   alu_out = op_a - op_b;
            ALU_SLL:   alu_out = op_a << shamt;
            ALU_SLT:   alu_out = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  alu_out = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:   alu_out = op_a ^ op_b;
            ALU_SRL:   alu_out = op_a >> shamt;
            ALU_SRA:   alu_out = $signed(op_a) >>> shamt;
            ALU_OR:    alu_out = op_a | op_b;
            ALU_AND:   alu_out = op_a & op_b;
            ALU_PASSB: alu_out = op_b;
            default:   alu_out = '0;
        endcase
    end

`ifdef EX_FAST_MUL_EN
    logic [2*XLEN-1:0] fm_a, fm_b, fm_prod;
    logic [XLEN-1:0]   fm_result;

    always_comb begin
        fm_a      = {{XLEN{((MdOp == MD_MULH) || (MdOp == MD_MULHSU)) && fwd_a[XLEN-1]}}, fwd_a};
        fm_b      = {{XLEN{(MdOp == MD_MULH) && fwd_b[XLEN-1]}}, fwd_b};
        fm_prod   = fm_a * fm_b;
        fm_result = (MdOp == MD_MUL) ? fm_prod[XLEN-1:0] : fm_prod[2*XLEN-1:XLEN];
    end

    assign md_iter = MdOp[2];
`else
    assign md_iter = 1'b1;
`endif

    // Stall starts in the issue cycle so ID/EX keeps presenting the operands.
    assign md_start = ex_valid && MdEn && md_iter && !md_busy && !md_done;
    assign ex_stall = (md_start || md_busy) && !flush;

    ex_muldiv_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .flush  (flush),
        .hold   (mem_stall),
        .op     (MdOp),
        .a      (fwd_a),
        .b      (fwd_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    always_comb begin
        next_result = alu_out;
        if (md_done) next_result = md_result;
`ifdef EX_FAST_MUL_EN
        else if (MdEn && !MdOp[2]) next_result = fm_result;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid  <= 1'b0;
            mem_result <= '0;
            mem_DataB  <= '0;
        end else if (!mem_stall && !ex_stall) begin
            mem_valid  <= ex_valid && !flush;
            mem_result <= next_result;
            mem_DataB  <= fwd_b;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ex_stage_md.sv
// ============================================================================
//  Module      : tb_ex_stage_md
//  Description : Directed self-checking bench for ex_stage_md (XLEN=32).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_stage_md;
    import ex_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ex_valid, flush, mem_stall;
    logic [XLEN-1:0] ex_pc, ex_DataA, ex_DataB, imm, mem_ALU_out, wb_WBData;
    logic [1:0]      ForwardASel, ForwardBSel;
    logic            ASel, BSel, BrUn;
    logic [3:0]      ALUSel;
    logic            MdEn;
    logic [2:0]      MdOp;
    logic            BrEq, BrLT, ex_stall, mem_valid;
    logic [XLEN-1:0] mem_result, mem_DataB;

    int n_tests = 0;
    int n_fail  = 0;

    ex_stage_md #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .flush(flush),
        .mem_stall(mem_stall), .ex_pc(ex_pc), .ex_DataA(ex_DataA),
        .ex_DataB(ex_DataB), .imm(imm), .mem_ALU_out(mem_ALU_out),
        .wb_WBData(wb_WBData), .ForwardASel(ForwardASel),
        .ForwardBSel(ForwardBSel), .ASel(ASel), .BSel(BSel), .BrUn(BrUn),
        .ALUSel(ALUSel), .MdEn(MdEn), .MdOp(MdOp), .BrEq(BrEq), .BrLT(BrLT),
        .ex_stall(ex_stall), .mem_valid(mem_valid), .mem_result(mem_result),
        .mem_DataB(mem_DataB)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        ex_valid = 0; flush = 0; mem_stall = 0; ex_pc = 0; ex_DataA = 0;
        ex_DataB = 0; imm = 0; mem_ALU_out = 0; wb_WBData = 0;
        ForwardASel = 0; ForwardBSel = 0; ASel = 0; BSel = 0; BrUn = 0;
        ALUSel = ALU_ADD; MdEn = 0; MdOp = MD_MUL;
    endtask

    task automatic alu_op(input string tag, input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        nop();
        ex_valid = 1; ALUSel = sel; ex_DataA = a; ex_DataB = b;
        tick();
        nop();
        check(tag, mem_result, exp);
    endtask

    // Issues an M-op, counts stall cycles, then checks the captured result.
    task automatic md_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int n;
        int exp_stall;
        exp_stall = 33;
`ifdef EX_FAST_MUL_EN
        if (!op[2]) exp_stall = 0;
`endif
        nop();
        ex_valid = 1; MdEn = 1; MdOp = op; ex_DataA = a; ex_DataB = b;
        #1;
        n = 0;
        while (ex_stall && n < 100) begin
            n++;
            tick();
        end
        check({tag, "_stall"}, 64'(n), 64'(exp_stall));
        tick();
        nop();
        check(tag, mem_result, exp);
        check({tag, "_valid"}, mem_valid, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        nop();
        rst_n = 0;
        tick();
        check("rst_valid", mem_valid, 1'b0);
        check("rst_result", mem_result, 0);
        check("rst_datab", mem_DataB, 0);
        check("rst_stall", ex_stall, 1'b0);
        rst_n = 1;
        tick();

        // Forwarding: A from MEM, B from WB
        ex_valid = 1; ALUSel = ALU_ADD; ex_DataA = 100; ex_DataB = 200;
        ForwardASel = 2; mem_ALU_out = 5; ForwardBSel = 1; wb_WBData = 7;
        #1;
        check("fwd_brlt", BrLT, 1'b1);
        check("fwd_breq", BrEq, 1'b0);
        tick();
        check("fwd_add", mem_result, 12);
        check("fwd_valid", mem_valid, 1'b1);
        check("fwd_datab", mem_DataB, 7);

        // Branch comparator signedness
        nop();
        ex_DataA = 32'hFFFF_FFFF; ex_DataB = 1;
        #1;
        check("brlt_signed", BrLT, 1'b1);
        BrUn = 1;
        #1;
        check("brlt_unsigned", BrLT, 1'b0);
        ex_DataB = 32'hFFFF_FFFF;
        #1;
        check("breq", BrEq, 1'b1);

        // PC + imm path
        nop();
        ex_valid = 1; ALUSel = ALU_SUB; ASel = 1; BSel = 1; ex_pc = 32'h100; imm = 32'h10;
        tick();
        check("pc_sub_imm", mem_result, 32'hF0);

        alu_op("slt",  ALU_SLT,  32'hFFFF_FFFF, 1, 1);
        alu_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 1, 0);
        alu_op("sra",  ALU_SRA,  32'h8000_0000, 32'h24, 32'hF800_0000);
        alu_op("srl",  ALU_SRL,  32'h8000_0000, 32'h24, 32'h0800_0000);
        alu_op("sll",  ALU_SLL,  32'h0000_0003, 32'h21, 32'h0000_0006);

        md_op("mulh",   MD_MULH,   32'hFFFF_FFFF, 2, 32'hFFFF_FFFF);
        md_op("mul",    MD_MUL,    7, 6, 42);
        md_op("mulhu",  MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        md_op("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        md_op("div0",   MD_DIV,    17, 0, 32'hFFFF_FFFF);
        md_op("rem0",   MD_REM,    17, 0, 17);
        md_op("divovf", MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        md_op("removf", MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0);
        md_op("divneg", MD_DIV,    32'hFFFF_FFF9, 2, 32'hFFFF_FFFD);
        md_op("remneg", MD_REM,    32'hFFFF_FFF9, 2, 32'hFFFF_FFFF);
        md_op("divu",   MD_DIVU,   32'hFFFF_FFFF, 16, 32'h0FFF_FFFF);

        // Flush during BUSY; mem_valid is 1 from the previous M-op
        nop();
        ex_valid = 1; MdEn = 1; MdOp = MD_DIV; ex_DataA = 100; ex_DataB = 3;
        for (int i = 0; i < 11; i++) tick();
        check("flush_pre_stall", ex_stall, 1'b1);
        flush = 1;
        tick();
        nop();
        ex_valid = 1; ALUSel = ALU_ADD; ex_DataA = 3; ex_DataB = 4;
        #1;
        check("flush_stall", ex_stall, 1'b0);
        check("flush_valid", mem_valid, 1'b0);
        tick();
        nop();
        check("post_flush_add", mem_result, 7);
        check("post_flush_valid", mem_valid, 1'b1);

        // mem_stall held in DONE
        ex_valid = 1; MdEn = 1; MdOp = MD_DIV; ex_DataA = 100; ex_DataB = 7;
        #1;
        for (int i = 0; i < 100 && ex_stall; i++) tick();
        mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mstall_hold", mem_result, 7);
            check("mstall_nostall", ex_stall, 1'b0);
        end
        mem_stall = 0;
        tick();
        nop();
        check("mstall_release", mem_result, 14);

        // Async reset mid-BUSY
        ex_valid = 1; MdEn = 1; MdOp = MD_MULHU; ex_DataA = 9; ex_DataB = 9;
        for (int i = 0; i < 6; i++) tick();
        #2;
        nop();
        rst_n = 0;
        #1;
        check("arst_valid", mem_valid, 1'b0);
        check("arst_result", mem_result, 0);
        check("arst_datab", mem_DataB, 0);
        check("arst_stall", ex_stall, 1'b0);
        tick();
        rst_n = 1;
        tick();
        alu_op("arst_add", ALU_ADD, 20, 22, 42);
        md_op("arst_mul", MD_MUL, 3, 5, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
